wb_regfile: RTL and testbench

//   Write-back end of the MEM/WB pipeline interface: consumes wb_wd/wb_wreg/wb_wdata and
//   wb_whilo/wb_hi/wb_lo, commits them to the 32x32 GPR file and the HI/LO pair.

---
 rtl/wb_regfile_pkg.sv | 21 ++
 rtl/wb_regfile_if.sv | 36 +++
 rtl/wb_regfile_hilo_reg.sv | 48 ++++
 rtl/wb_regfile.sv | 90 +++++++++
 tb/tb_wb_regfile.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file: reset polarity, enable levels and the
// hardwired-zero register address.
package wb_regfile_pkg;

  localparam logic RstnEnable   = 1'b0;
  localparam logic RstnDisable  = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefAddrW  = 5;
  localparam int unsigned DefRegNum = 32;
  localparam int unsigned DefCntW   = 32;

  // A write-back retires an instruction if it touches a real GPR or the HI/LO pair.
  function automatic logic is_commit(input logic gpr_we, input logic hilo_we);
    return gpr_we || hilo_we;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus plus the ID-stage GPR read ports and EX-stage HI/LO read port.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair with write-through bypass; both halves always update together.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we == WriteEnable) begin
      hi_d = hi_wdata;
      lo_d = lo_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    hi_rdata = '0;
    lo_rdata = '0;
    if (rst == RstnDisable) begin
      hi_rdata = hi_d;
      lo_rdata = lo_d;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back end of MEM/WB: 32-entry GPR file with two bypassed read ports, HI/LO pair and a
// retired write-back counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned REG_NUM = DefRegNum,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  wb_regfile_if.slave      bus,
  output logic [CNT_W-1:0] commit_cnt
);

  localparam logic [ADDR_W-1:0] NopRegAddr = '0;

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic              gpr_we;
  logic              hilo_we;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Writes to $0 are dropped, so they neither update storage nor count as a commit.
  assign gpr_we  = (bus.wb_wreg == WriteEnable) && (bus.wb_wd != NopRegAddr);
  assign hilo_we = (bus.wb_whilo == WriteEnable);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
      end
    end else if (gpr_we) begin
      regs_q[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  always_comb begin
    bus.rdata1 = '0;
    if (rst == RstnDisable && bus.re1 == ReadEnable && bus.raddr1 != NopRegAddr) begin
      if (gpr_we && bus.raddr1 == bus.wb_wd) begin
        bus.rdata1 = bus.wb_wdata;
      end else begin
        bus.rdata1 = regs_q[bus.raddr1];
      end
    end
  end

  always_comb begin
    bus.rdata2 = '0;
    if (rst == RstnDisable && bus.re2 == ReadEnable && bus.raddr2 != NopRegAddr) begin
      if (gpr_we && bus.raddr2 == bus.wb_wd) begin
        bus.rdata2 = bus.wb_wdata;
      end else begin
        bus.rdata2 = regs_q[bus.raddr2];
      end
    end
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .we       (hilo_we),
    .hi_wdata (bus.wb_hi),
    .lo_wdata (bus.wb_lo),
    .hi_rdata (bus.hi_o),
    .lo_rdata (bus.lo_o)
  );

  // A simultaneous GPR and HI/LO write is a single retired instruction.
  always_comb begin
    cnt_d = cnt_q;
    if (is_commit(gpr_we, hilo_we)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based architectural model.
module tb_wb_regfile;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CntW-1:0] commit_cnt;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .REG_NUM (32),
    .CNT_W   (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int unsigned m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 5'd0) return '0;
    if (bus.wb_wreg && bus.wb_wd == a) return bus.wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic re1, input logic [4:0] a1,
                       input logic re2, input logic [4:0] a2);
    bus.wb_wreg  = wreg;
    bus.wb_wd    = wd;
    bus.wb_wdata = wdata;
    bus.wb_whilo = whilo;
    bus.wb_hi    = hi;
    bus.wb_lo    = lo;
    bus.re1      = re1;
    bus.raddr1   = a1;
    bus.re2      = re2;
    bus.raddr2   = a2;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".rdata1"}, bus.rdata1, exp_read(bus.re1, bus.raddr1));
    check_eq({tag, ".rdata2"}, bus.rdata2, exp_read(bus.re2, bus.raddr2));
    check_eq({tag, ".hi"}, bus.hi_o, !rst ? 32'd0 : (bus.wb_whilo ? bus.wb_hi : m_hi));
    check_eq({tag, ".lo"}, bus.lo_o, !rst ? 32'd0 : (bus.wb_whilo ? bus.wb_lo : m_lo));
  endtask

  // Advance one clock, apply the architectural effect of the current inputs, check the counter.
  task automatic clock_edge(input string tag);
    logic gw;
    @(posedge clk);
    if (rst) begin
      gw = bus.wb_wreg && bus.wb_wd != 5'd0;
      if (gw) m_gpr[bus.wb_wd] = bus.wb_wdata;
      if (bus.wb_whilo) begin
        m_hi = bus.wb_hi;
        m_lo = bus.wb_lo;
      end
      if (gw || bus.wb_whilo) m_cnt = (m_cnt + 1) % (32'd1 << CntW);
    end
    #1;
    check_eq({tag, ".cnt"}, 32'(commit_cnt), m_cnt);
  endtask

  task automatic cycle(input string tag, input logic wreg, input logic [4:0] wd,
                       input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
                       input logic [31:0] lo, input logic re1, input logic [4:0] a1,
                       input logic re2, input logic [4:0] a2);
    drive(wreg, wd, wdata, whilo, hi, lo, re1, a1, re2, a2);
    #1;
    check_outputs(tag);
    clock_edge(tag);
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    model_clear();
    drive(1'b1, 5'd4, 32'h1111_2222, 1'b1, 32'h1, 32'h2, 1'b1, 5'd4, 1'b1, 5'd4);
    #2;
    check_outputs("reset");
    check_eq("reset.cnt", 32'(commit_cnt), 32'd0);
    #5 rst = 1'b1;

    // Counter wrap: sixteen GPR writes bring a 4-bit counter back to zero.
    for (int i = 1; i <= 16; i++) begin
      cycle("wrap", 1'b1, 5'(i), $urandom, 1'b0, 32'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(i - 1));
      if (i == 15) check_eq("wrap.cnt15", 32'(commit_cnt), 32'd15);
      if (i == 16) check_eq("wrap.cnt0", 32'(commit_cnt), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle("bubble", 1'b0, rand_addr(), $urandom, 1'b0, $urandom, $urandom,
            1'b1, rand_addr(), 1'b1, rand_addr());
    end

    cycle("wr5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    check_eq("wr5.cnt1", 32'(commit_cnt), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    #1;
    check_eq("rd5", bus.rdata1, 32'hDEAD_BEEF);
    clock_edge("rd5");

    drive(1'b1, 5'd7, 32'h1234_5678, 1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    check_eq("byp.rd1", bus.rdata1, 32'h1234_5678);
    check_eq("byp.rd2", bus.rdata2, 32'h1234_5678);
    bus.re2 = 1'b0;
    #1;
    check_eq("byp.re2off", bus.rdata2, 32'd0);
    clock_edge("byp");

    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    #1;
    check_eq("r0.same", bus.rdata1, 32'd0);
    clock_edge("r0");
    cycle("r0.next", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd7);

    drive(1'b1, 5'd3, 32'h0303_0303, 1'b1, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    check_eq("hilo.byp_hi", bus.hi_o, 32'hAAAA_0000);
    check_eq("hilo.byp_lo", bus.lo_o, 32'h0000_BBBB);
    clock_edge("hilo");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'h5555_5555, 32'h6666_6666, 1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    check_eq("hilo.hold_hi", bus.hi_o, 32'hAAAA_0000);
    check_eq("hilo.hold_lo", bus.lo_o, 32'h0000_BBBB);
    check_eq("hilo.rd3", bus.rdata1, 32'h0303_0303);
    clock_edge("hilo.hold");

    for (int i = 0; i < 400; i++) begin
      cycle("rand", $urandom_range(0, 2) != 0, rand_addr(), $urandom,
            $urandom_range(0, 9) < 3, $urandom, $urandom,
            $urandom_range(0, 7) != 0, rand_addr(), $urandom_range(0, 7) != 0, rand_addr());
    end

    // Mid-stream reset with no clock edge, then writes held off until release.
    drive(1'b1, 5'd7, 32'hCAFE_F00D, 1'b1, 32'h7, 32'h8, 1'b1, 5'd5, 1'b1, 5'd3);
    rst = 1'b0;
    model_clear();
    #1;
    check_outputs("midrst");
    check_eq("midrst.cnt", 32'(commit_cnt), 32'd0);
    clock_edge("midrst.held");
    rst = 1'b1;
    cycle("postrst", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd7);
    cycle("postrst.wr", 1'b1, 5'd9, 32'h0BAD_CAFE, 1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0);
    check_eq("postrst.cnt1", 32'(commit_cnt), 32'd1);
    cycle("postrst.rd", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
